morse2ascii: RTL and testbench

Receive-side counterpart of ascii2morse. Samples an on-off-keyed Morse line, classifies marks and gaps against a unit time of PRESCALER clocks, and decodes each character to ASCII. Decoded bytes go into a small first-word-fall-through FIFO that the host drains. Used for loopback checking of ascii2morse and as the receive path of a Morse link.

---
 rtl/morse_pkg.sv | 76 +++++++
 rtl/morse_rx_fifo.sv | 55 +++++
 rtl/morse2ascii.sv | 111 +++++++++++
 tb/tb_morse2ascii.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse timing constants and the code table.
// The transmitter uses the same table, so encode and decode stay in step.
package morse_pkg;

    localparam int unsigned DOT_MAX_UNITS  = 2;
    localparam int unsigned CHAR_GAP_UNITS = 2;
    localparam int unsigned WORD_GAP_UNITS = 5;
    localparam int unsigned MAX_ELEMS      = 6;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    // code holds the low len bits, first element in the MSB; dot=0, dash=1.
    function automatic logic [7:0] morse_lookup(input logic [5:0] code, input logic [2:0] len);
        logic [7:0] c;
        c = ASCII_UNKNOWN;
        case (len)
            3'd1: c = code[0] ? 8'h54 : 8'h45;
            3'd2: begin
                case (code[1:0])
                    2'b00:   c = 8'h49;
                    2'b01:   c = 8'h41;
                    2'b10:   c = 8'h4E;
                    default: c = 8'h4D;
                endcase
            end
            3'd3: begin
                case (code[2:0])
                    3'b000:  c = 8'h53;
                    3'b001:  c = 8'h55;
                    3'b010:  c = 8'h52;
                    3'b011:  c = 8'h57;
                    3'b100:  c = 8'h44;
                    3'b101:  c = 8'h4B;
                    3'b110:  c = 8'h47;
                    default: c = 8'h4F;
                endcase
            end
            3'd4: begin
                case (code[3:0])
                    4'b0000: c = 8'h48;
                    4'b0001: c = 8'h56;
                    4'b0010: c = 8'h46;
                    4'b0100: c = 8'h4C;
                    4'b0110: c = 8'h50;
                    4'b0111: c = 8'h4A;
                    4'b1000: c = 8'h42;
                    4'b1001: c = 8'h58;
                    4'b1010: c = 8'h43;
                    4'b1011: c = 8'h59;
                    4'b1100: c = 8'h5A;
                    4'b1101: c = 8'h51;
                    default: c = ASCII_UNKNOWN;
                endcase
            end
            3'd5: begin
                case (code[4:0])
                    5'b11111: c = 8'h30;
                    5'b01111: c = 8'h31;
                    5'b00111: c = 8'h32;
                    5'b00011: c = 8'h33;
                    5'b00001: c = 8'h34;
                    5'b00000: c = 8'h35;
                    5'b10000: c = 8'h36;
                    5'b11000: c = 8'h37;
                    5'b11100: c = 8'h38;
                    5'b11110: c = 8'h39;
                    default:  c = ASCII_UNKNOWN;
                endcase
            end
            default: c = ASCII_UNKNOWN;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/morse_rx_fifo.sv
// First-word-fall-through FIFO for decoded characters.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module morse_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (PTR_W+1)'(DEPTH));
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Head reads as zero while empty so the output is defined after reset.
        rd_data = empty ? '0 : mem[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/morse2ascii.sv
// Morse receiver: synchronises the line, times marks and gaps in units of PRESCALER
// clocks, decodes each character and queues the ASCII result in a small FIFO.
module morse2ascii
    import morse_pkg::*;
#(
    parameter int unsigned PRESCALER = 100,
    parameter int unsigned DEPTH     = 4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       morse_in,
    input  logic       rd_en,
    output logic [7:0] ascii_out,
    output logic       empty,
    output logic       overrun
);

    localparam int unsigned SAT   = WORD_GAP_UNITS * PRESCALER;
    localparam int unsigned CNT_W = $clog2(SAT + 1);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SAT);
    localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(DOT_MAX_UNITS * PRESCALER);
    localparam logic [CNT_W-1:0] CHAR_GAP = CNT_W'(CHAR_GAP_UNITS * PRESCALER);
    localparam logic [2:0]       ELEM_TOO_LONG = 3'(MAX_ELEMS + 1);

    logic             s_meta, s_in;
    logic [CNT_W-1:0] mark_q, mark_d, gap_q, gap_d;
    logic [5:0]       code_q, code_d;
    logic [2:0]       elem_cnt_q, elem_cnt_d;
    logic             word_pending_q, word_pending_d;
    logic             overrun_q, overrun_d;
    logic             mark_end, char_end, word_end;
    logic             push, pop, full;
    logic [7:0]       push_data;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s_meta <= 1'b0;
            s_in   <= 1'b0;
        end else begin
            s_meta <= morse_in;
            s_in   <= s_meta;
        end
    end

    always_comb begin
        mark_d = '0;
        gap_d  = '0;
        if (s_in) mark_d = (mark_q == CNT_SAT) ? CNT_SAT : mark_q + 1'b1;
        else      gap_d  = (gap_q  == CNT_SAT) ? CNT_SAT : gap_q  + 1'b1;

        // mark_q still holds the finished mark length in the first space cycle.
        mark_end = ~s_in && (mark_q != '0);
        char_end = (gap_d == CHAR_GAP) && (gap_q != CHAR_GAP) && (elem_cnt_q != '0);
        word_end = (gap_d == CNT_SAT) && (gap_q != CNT_SAT) && word_pending_q;

        code_d         = code_q;
        elem_cnt_d     = elem_cnt_q;
        word_pending_d = word_pending_q;
        if (mark_end) begin
            code_d = {code_q[4:0], (mark_q >= DOT_LIM)};
            if (elem_cnt_q != ELEM_TOO_LONG) elem_cnt_d = elem_cnt_q + 1'b1;
        end
        if (char_end) begin
            code_d         = '0;
            elem_cnt_d     = '0;
            word_pending_d = 1'b1;
        end
        if (word_end) word_pending_d = 1'b0;

        push      = char_end | word_end;
        push_data = char_end ? morse_lookup(code_q, elem_cnt_q) : ASCII_SPACE;
        pop       = rd_en & ~empty;
        overrun_d = overrun_q | (push & full & ~pop);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            mark_q         <= '0;
            gap_q          <= '0;
            code_q         <= '0;
            elem_cnt_q     <= '0;
            word_pending_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            mark_q         <= mark_d;
            gap_q          <= gap_d;
            code_q         <= code_d;
            elem_cnt_q     <= elem_cnt_d;
            word_pending_q <= word_pending_d;
            overrun_q      <= overrun_d;
        end
    end

    morse_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .arst      (arst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .rd_data   (ascii_out),
        .full      (full),
        .empty     (empty)
    );

    assign overrun = overrun_q;

endmodule

// File: tb/tb_morse2ascii.sv
// Self-checking bench for morse2ascii: Morse stimulus from a local encoder, expected
// bytes queued in a scoreboard and compared as the host drains the FIFO.
module tb_morse2ascii;

    localparam int unsigned P = 4;

    logic       clk = 1'b0;
    logic       arst;
    logic       morse_in;
    logic       rd_en;
    logic [7:0] ascii_out;
    logic       empty;
    logic       overrun;

    int n_vectors     = 0;
    int n_miscompares = 0;
    logic [7:0] exp_q[$];

    morse2ascii #(
        .PRESCALER (P),
        .DEPTH     (4)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .morse_in  (morse_in),
        .rd_en     (rd_en),
        .ascii_out (ascii_out),
        .empty     (empty),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every entry at the head is popped at the next edge while rd_en is high.
    always @(negedge clk) begin
        if (!arst && rd_en && !empty) begin
            if (exp_q.size() == 0) check_eq("extra_byte", {24'h0, ascii_out}, 32'h100);
            else                   check_eq("byte", {24'h0, ascii_out}, {24'h0, exp_q.pop_front()});
        end
    end

    function automatic string enc(input byte c);
        case (c)
            "A": return ".-";
            "B": return "-...";
            "C": return "-.-.";
            "D": return "-..";
            "E": return ".";
            "F": return "..-.";
            "R": return ".-.";
            "T": return "-";
            default: return ".";
        endcase
    endfunction

    task automatic drive(input logic v, input int n);
        morse_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_code(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) begin
            drive(1'b1, (s[i] == "-") ? 3 * P : P);
            if (i != s.len() - 1) drive(1'b0, P);
        end
        drive(1'b0, last ? 7 * P : 3 * P);
    endtask

    task automatic send_word(input string w, input bit expect_out);
        for (int i = 0; i < w.len(); i++) begin
            if (expect_out) begin
                exp_q.push_back(w[i]);
                if (i == w.len() - 1) exp_q.push_back(8'h20);
            end
            send_code(enc(w[i]), i == w.len() - 1);
        end
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        repeat (40) @(posedge clk);
        #1;
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        arst     = 1'b1;
        morse_in = 1'b0;
        rd_en    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ascii", {24'h0, ascii_out}, 32'h0);
        check_eq("reset_empty", empty, 1);
        check_eq("reset_overrun", overrun, 0);
        arst = 1'b0;
        drive(1'b0, 30);
        rd_en = 1'b1;

        // Single dot, then a long idle: 'E', one space, nothing else.
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h20);
        drive(1'b1, P);
        drive(1'b0, 100);
        wait_drain("drain_e");

        send_word("ARE", 1'b1);
        send_word("RED", 1'b1);
        wait_drain("drain_are_red");
        check_eq("overrun_loopback", overrun, 0);

        // Dot/dash threshold at 2*P cycles.
        exp_q.push_back(8'h45); exp_q.push_back(8'h20);
        drive(1'b1, 2 * P - 1); drive(1'b0, 40);
        exp_q.push_back(8'h54); exp_q.push_back(8'h20);
        drive(1'b1, 2 * P); drive(1'b0, 40);
        // Character-gap threshold at 2*P cycles.
        exp_q.push_back(8'h41); exp_q.push_back(8'h20);
        drive(1'b1, P); drive(1'b0, 2 * P - 1); drive(1'b1, 3 * P); drive(1'b0, 40);
        exp_q.push_back(8'h45); exp_q.push_back(8'h54); exp_q.push_back(8'h20);
        drive(1'b1, P); drive(1'b0, 2 * P); drive(1'b1, 3 * P); drive(1'b0, 40);
        wait_drain("drain_bounds");

        exp_q.push_back(8'h3F); exp_q.push_back(8'h20);
        send_code("------", 1'b1);
        exp_q.push_back(8'h3F); exp_q.push_back(8'h20);
        send_code(".......", 1'b1);
        exp_q.push_back(8'h30); exp_q.push_back(8'h20);
        send_code("-----", 1'b1);
        wait_drain("drain_unknown");

        // Overflow with the host stalled.
        rd_en = 1'b0;
        send_word("ABCDEF", 1'b0);
        check_eq("overflow_overrun", overrun, 1);
        check_eq("overflow_empty", empty, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h41 + 8'(i));
        rd_en = 1'b1;
        wait_drain("drain_overflow");
        check_eq("drained_empty", empty, 1);
        check_eq("overrun_sticky", overrun, 1);

        // Reset mid-dash with a byte waiting in the FIFO.
        rd_en = 1'b0;
        send_word("E", 1'b0);
        drive(1'b1, 6);
        arst = 1'b1;
        drive(1'b1, 3);
        check_eq("midreset_ascii", {24'h0, ascii_out}, 32'h0);
        check_eq("midreset_empty", empty, 1);
        check_eq("midreset_overrun", overrun, 0);
        morse_in = 1'b0;
        drive(1'b0, 2);
        arst = 1'b0;
        drive(1'b0, 30);
        rd_en = 1'b1;
        send_word("E", 1'b1);
        wait_drain("drain_after_reset");
        check_eq("final_overrun", overrun, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
